// File: rtl/serial_addsub_mux.sv
// Bit-serial WIDTH-bit adder/subtractor: operands are loaded in parallel and
// streamed LSB-first through one mux-based full-adder cell with a carry flip-flop.
module serial_addsub_mux #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sr_q;
    logic [WIDTH-1:0]   b_sr_q;
    logic [WIDTH-2:0]   res_sr_q;
    logic [WIDTH-1:0]   result_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               sub_q;
    logic               carry_q;
    logic               c_msb_q;
    logic               cout_q;
    logic               overflow_q;

    logic               b_eff;
    logic               prop;
    logic               fa_s;
    logic               fa_c;
    logic [WIDTH-1:0]   res_sr_d;

    // Mux-based full adder: the propagate bit selects between carry and its
    // inverse for the sum, and between carry-in and the A bit for carry-out.
    assign b_eff    = b_sr_q[0] ^ sub_q;
    assign prop     = a_sr_q[0] ^ b_eff;
    assign fa_s     = prop ? ~carry_q : carry_q;
    assign fa_c     = prop ? carry_q : a_sr_q[0];

    // Only the upper WIDTH-1 result bits need storing; the newest sum bit is
    // merged in combinationally so the final edge can load the full result.
    assign res_sr_d = {fa_s, res_sr_q};

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, and the datapath registers are
    // cleared by reset too, so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            res_sr_q   <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            sub_q      <= 1'b0;
            carry_q    <= 1'b0;
            c_msb_q    <= 1'b0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sr_q  <= a_in;
                        b_sr_q  <= b_in;
                        sub_q   <= sub;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    res_sr_q <= res_sr_d[WIDTH-1:1];
                    carry_q  <= fa_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 2)) begin
                        c_msb_q <= fa_c;
                    end
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // c_msb_q holds the carry into the MSB, fa_c the carry out.
                        result_q   <= res_sr_d;
                        cout_q     <= fa_c;
                        overflow_q <= fa_c ^ c_msb_q;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule
